// File: rtl/res_seq.sv
// res_seq: reset sequencer. Synchronizes release of an async active-low
// reset, holds all domains in reset for HOLD_CYCLES, then releases the
// domain resets one at a time, bit 0 first, GAP_CYCLES apart. While running,
// a soft-reset request replays the hold/release sequence once per request
// and acknowledges completion with a one-cycle pulse.
module res_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYCLES = 16,
   parameter int GAP_CYCLES  = 4,
   parameter int NUM_DOMAINS = 4
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   soft_req,
   output logic [NUM_DOMAINS-1:0] res_out,
   output logic                   ready,
   output logic                   soft_ack
);

   // One shared counter covers both the hold and the gap intervals; it
   // counts down from (interval-1) so a zero test marks the final edge.
   localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [IDX_W-1:0] FIRST_GAP = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   res_sync;

   state_t                 state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic [IDX_W-1:0]       idx, idx_nxt;
   logic [NUM_DOMAINS-1:0] res_out_nxt;
   logic                   ready_nxt;
   logic                   soft_ack_nxt;
   logic                   armed, armed_nxt;
   logic                   soft_flag, soft_flag_nxt;

   // Deassertion synchronizer: cleared asynchronously, fills with ones so
   // the release reaches the FSM only after SYNC_STAGES clean edges.
   always_ff @(posedge clk or negedge res) begin
      if (!res) sync_q <= '0;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign res_sync = sync_q[SYNC_STAGES-1];

   // State register: every output is a flop, cleared asynchronously so a
   // reset pulse of any width aborts whatever sequence is in flight.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state     <= ST_ASSERT;
         cnt       <= '0;
         idx       <= '0;
         res_out   <= '0;
         ready     <= 1'b0;
         soft_ack  <= 1'b0;
         armed     <= 1'b1;
         soft_flag <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         res_out   <= res_out_nxt;
         ready     <= ready_nxt;
         soft_ack  <= soft_ack_nxt;
         armed     <= armed_nxt;
         soft_flag <= soft_flag_nxt;
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      idx_nxt       = idx;
      res_out_nxt   = res_out;
      ready_nxt     = ready;
      soft_ack_nxt  = 1'b0;
      // Any edge that sees the request low re-arms, so a held request
      // yields exactly one soft reset.
      armed_nxt     = armed | ~soft_req;
      soft_flag_nxt = soft_flag;

      case (state)
         ST_ASSERT: begin
            res_out_nxt = '0;
            ready_nxt   = 1'b0;
            if (res_sync) begin
               state_nxt = ST_HOLD;
               cnt_nxt   = HOLD_LOAD;
            end
         end

         ST_HOLD: begin
            if (cnt == '0) begin
               res_out_nxt[0] = 1'b1;
               if (NUM_DOMAINS == 1) begin
                  state_nxt     = ST_RUN;
                  ready_nxt     = 1'b1;
                  soft_ack_nxt  = soft_flag;
                  soft_flag_nxt = 1'b0;
               end else begin
                  state_nxt = ST_RELEASE;
                  idx_nxt   = FIRST_GAP;
                  cnt_nxt   = GAP_LOAD;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            if (cnt == '0) begin
               // idx is never 0 here, so exactly one new bit is released.
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (idx == IDX_W'(i)) res_out_nxt[i] = 1'b1;
               end
               if (idx == LAST_IDX) begin
                  state_nxt     = ST_RUN;
                  ready_nxt     = 1'b1;
                  soft_ack_nxt  = soft_flag;
                  soft_flag_nxt = 1'b0;
               end else begin
                  idx_nxt = idx + IDX_W'(1);
                  cnt_nxt = GAP_LOAD;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (soft_req && armed) begin
               state_nxt     = ST_HOLD;
               res_out_nxt   = '0;
               ready_nxt     = 1'b0;
               armed_nxt     = 1'b0;
               soft_flag_nxt = 1'b1;
               cnt_nxt       = HOLD_LOAD;
               idx_nxt       = '0;
            end
         end

         default: begin
            state_nxt   = ST_ASSERT;
            res_out_nxt = '0;
            ready_nxt   = 1'b0;
         end
      endcase
   end

endmodule
